// File: rtl/video_postproc.sv
// Output-domain post-processing: fade expansion, scanline darkening and border masking.
// Configuration is shadowed on the vsync leading edge so a frame never sees a mid-frame change.
module video_postproc #(
  parameter int NUM_CH    = 3,
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8,
  parameter int HCNT_W    = 12,
  parameter int VCNT_W    = 11
) (
  input  logic                         pclk_act,
  input  logic                         reset_n,
  input  logic [HCNT_W-1:0]            hcnt_in,
  input  logic [VCNT_W-1:0]            vcnt_in,
  input  logic [2:0]                   line_id_in,
  input  logic [2:0]                   col_id_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         de_in,
  input  logic [NUM_CH*IN_BITS-1:0]    pix_in,
  input  logic [FADE_BITS-1:0]         fade_in,
  input  logic [1:0]                   cfg_sl_mode,
  input  logic [OUT_BITS-1:0]          cfg_sl_str,
  input  logic [7:0]                   cfg_sl_mask,
  input  logic [HCNT_W-1:0]            cfg_h_start,
  input  logic [HCNT_W-1:0]            cfg_h_active,
  input  logic [HCNT_W-1:0]            cfg_h_mask,
  input  logic [VCNT_W-1:0]            cfg_v_start,
  input  logic [VCNT_W-1:0]            cfg_v_active,
  input  logic [VCNT_W-1:0]            cfg_v_mask,
  input  logic [3:0]                   cfg_mask_br,
  output logic [NUM_CH*OUT_BITS-1:0]   pix_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic                         de_out,
  output logic                         frame_parity
);

  localparam int PW = IN_BITS + FADE_BITS + 1;
  localparam int SW = (PW > OUT_BITS) ? PW : OUT_BITS;
  localparam int HS = HCNT_W + 2;
  localparam int VS = VCNT_W + 2;
  localparam logic [SW-1:0] OUT_MAX = SW'({OUT_BITS{1'b1}});

  logic [1:0]          sh_sl_mode;
  logic [OUT_BITS-1:0] sh_sl_str;
  logic [7:0]          sh_sl_mask;
  logic [HCNT_W-1:0]   sh_h_start, sh_h_active, sh_h_mask;
  logic [VCNT_W-1:0]   sh_v_start, sh_v_active, sh_v_mask;
  logic [3:0]          sh_mask_br;
  logic                vs_prev;
  logic                vs_edge;

  assign vs_edge = vs_prev & ~vsync_in;

  always_ff @(posedge pclk_act or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev      <= 1'b1;
      frame_parity <= 1'b0;
      sh_sl_mode   <= '0;
      sh_sl_str    <= '0;
      sh_sl_mask   <= '0;
      sh_h_start   <= '0;
      sh_h_active  <= '0;
      sh_h_mask    <= '0;
      sh_v_start   <= '0;
      sh_v_active  <= '0;
      sh_v_mask    <= '0;
      sh_mask_br   <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_edge) begin
        frame_parity <= ~frame_parity;
        sh_sl_mode   <= cfg_sl_mode;
        sh_sl_str    <= cfg_sl_str;
        sh_sl_mask   <= cfg_sl_mask;
        sh_h_start   <= cfg_h_start;
        sh_h_active  <= cfg_h_active;
        sh_h_mask    <= cfg_h_mask;
        sh_v_start   <= cfg_v_start;
        sh_v_active  <= cfg_v_active;
        sh_v_mask    <= cfg_v_mask;
        sh_mask_br   <= cfg_mask_br;
      end
    end
  end

  // Pipeline registers; index n of a delay line is n cycles after its first capture.
  logic [HCNT_W-1:0]          hcnt_q;
  logic [VCNT_W-1:0]          vcnt_q;
  logic [2:0]                 line_d [4];
  logic [2:0]                 col_d  [4];
  logic [3:0]                 mask_d;
  logic [2:0]                 sync_d [4];
  logic [NUM_CH*IN_BITS-1:0]  pix_q;
  logic [FADE_BITS-1:0]       fade_q;
  logic [NUM_CH*OUT_BITS-1:0] f_q, s_q;

  // Signed bounds so a border wider than the active window masks everything instead of wrapping.
  logic signed [HS-1:0] h_pos, h_lo, h_hi;
  logic signed [VS-1:0] v_pos, v_lo, v_hi;
  logic                 mask_now;

  always_comb begin
    h_pos = $signed({2'b00, hcnt_q});
    h_lo  = $signed({2'b00, sh_h_start}) + $signed({2'b00, sh_h_mask});
    h_hi  = $signed({2'b00, sh_h_start}) + $signed({2'b00, sh_h_active})
          - $signed({2'b00, sh_h_mask});
    v_pos = $signed({2'b00, vcnt_q});
    v_lo  = $signed({2'b00, sh_v_start}) + $signed({2'b00, sh_v_mask});
    v_hi  = $signed({2'b00, sh_v_start}) + $signed({2'b00, sh_v_active})
          - $signed({2'b00, sh_v_mask});
    mask_now = (h_pos < h_lo) || (h_pos >= h_hi) || (v_pos < v_lo) || (v_pos >= v_hi);
  end

  logic [PW-1:0]              prod;
  logic [NUM_CH*OUT_BITS-1:0] fade_val;

  always_comb begin
    prod     = '0;
    fade_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prod = PW'(pix_q[c*IN_BITS +: IN_BITS]) * (PW'(fade_q) + PW'(2));
      if (SW'(prod) > OUT_MAX) fade_val[c*OUT_BITS +: OUT_BITS] = '1;
      else                     fade_val[c*OUT_BITS +: OUT_BITS] = OUT_BITS'(prod);
    end
  end

  logic                       dark;
  logic [OUT_BITS-1:0]        ch;
  logic [NUM_CH*OUT_BITS-1:0] sl_val;

  always_comb begin
    case (sh_sl_mode)
      2'd1:    dark = sh_sl_mask[line_d[3]];
      2'd2:    dark = (col_d[3] == 3'd0);
      2'd3:    dark = sh_sl_mask[line_d[3]] ^ frame_parity;
      default: dark = 1'b0;
    endcase
    ch     = '0;
    sl_val = f_q;
    if (dark) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch = f_q[c*OUT_BITS +: OUT_BITS];
        sl_val[c*OUT_BITS +: OUT_BITS] = (ch > sh_sl_str) ? ch - sh_sl_str : '0;
      end
    end
  end

  logic [OUT_BITS-1:0]        br_val;
  logic [NUM_CH*OUT_BITS-1:0] bd_val;

  assign br_val = {sh_mask_br, {(OUT_BITS-4){1'b0}}};
  assign bd_val = mask_d[3] ? {NUM_CH{br_val}} : s_q;

  always_ff @(posedge pclk_act or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      mask_d    <= '0;
      pix_q     <= '0;
      fade_q    <= '0;
      f_q       <= '0;
      s_q       <= '0;
      pix_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      de_out    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        line_d[i] <= '0;
        col_d[i]  <= '0;
        sync_d[i] <= 3'b110;
      end
    end else begin
      hcnt_q    <= hcnt_in;
      vcnt_q    <= vcnt_in;
      line_d[0] <= line_id_in;
      col_d[0]  <= col_id_in;
      mask_d    <= {mask_d[2:0], mask_now};
      sync_d[0] <= {hsync_in, vsync_in, de_in};
      for (int i = 1; i < 4; i++) begin
        line_d[i] <= line_d[i-1];
        col_d[i]  <= col_d[i-1];
        sync_d[i] <= sync_d[i-1];
      end
      pix_q     <= pix_in;
      fade_q    <= fade_in;
      f_q       <= fade_val;
      s_q       <= sl_val;
      pix_out   <= bd_val;
      {hsync_out, vsync_out, de_out} <= sync_d[3];
    end
  end

endmodule

// File: tb/tb_video_postproc.sv
// Randomised bench for video_postproc: per-pixel records are streamed through the skewed
// input stages and a frame-level reference model predicts each output cycle.
`timescale 1ns/1ps
module tb_video_postproc;

  localparam int NCH     = 3;
  localparam int OB      = 8;
  localparam int FRAME   = 120;
  localparam int NFRAMES = 16;
  localparam int NCYC    = FRAME * NFRAMES + 8;
  localparam int RST_A   = FRAME * 10 + 47;
  localparam int EW      = 2 * NCH * OB + 3;

  // clock / reset
  logic pclk_act = 1'b0;
  logic reset_n  = 1'b0;
  always #5 pclk_act = ~pclk_act;

  logic [11:0] hcnt_in;
  logic [10:0] vcnt_in;
  logic [2:0]  line_id_in, col_id_in;
  logic        hsync_in, vsync_in, de_in;
  logic [11:0] pix_in;
  logic [3:0]  fade_in;
  logic        fade_hi;
  logic [4:0]  fade2;
  logic [1:0]  cfg_sl_mode;
  logic [7:0]  cfg_sl_str, cfg_sl_mask;
  logic [11:0] cfg_h_start, cfg_h_active, cfg_h_mask;
  logic [10:0] cfg_v_start, cfg_v_active, cfg_v_mask;
  logic [3:0]  cfg_mask_br;
  logic [23:0] pix_out, pix_out2;
  logic        hsync_out, vsync_out, de_out, frame_parity;
  logic        hs2, vs2, de2, par2;

  assign fade2 = {fade_hi, fade_in};

  video_postproc dut (
    .pclk_act(pclk_act), .reset_n(reset_n), .hcnt_in(hcnt_in), .vcnt_in(vcnt_in),
    .line_id_in(line_id_in), .col_id_in(col_id_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .pix_in(pix_in), .fade_in(fade_in), .cfg_sl_mode(cfg_sl_mode),
    .cfg_sl_str(cfg_sl_str), .cfg_sl_mask(cfg_sl_mask), .cfg_h_start(cfg_h_start),
    .cfg_h_active(cfg_h_active), .cfg_h_mask(cfg_h_mask), .cfg_v_start(cfg_v_start),
    .cfg_v_active(cfg_v_active), .cfg_v_mask(cfg_v_mask), .cfg_mask_br(cfg_mask_br),
    .pix_out(pix_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .frame_parity(frame_parity)
  );

  video_postproc #(.FADE_BITS(5)) dut5 (
    .pclk_act(pclk_act), .reset_n(reset_n), .hcnt_in(hcnt_in), .vcnt_in(vcnt_in),
    .line_id_in(line_id_in), .col_id_in(col_id_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .pix_in(pix_in), .fade_in(fade2), .cfg_sl_mode(cfg_sl_mode),
    .cfg_sl_str(cfg_sl_str), .cfg_sl_mask(cfg_sl_mask), .cfg_h_start(cfg_h_start),
    .cfg_h_active(cfg_h_active), .cfg_h_mask(cfg_h_mask), .cfg_v_start(cfg_v_start),
    .cfg_v_active(cfg_v_active), .cfg_v_mask(cfg_v_mask), .cfg_mask_br(cfg_mask_br),
    .pix_out(pix_out2), .hsync_out(hs2), .vsync_out(vs2), .de_out(de2),
    .frame_parity(par2)
  );

  typedef struct { int h, v, line, col, hs, vs, de, pix, fade, fhi, frame; } rec_t;
  typedef struct { int mode, str, slm, hs, ha, hm, vs, va, vm, br, par; } cfg_t;

  rec_t rec  [NCYC+8];
  cfg_t drv  [NCYC+8];
  cfg_t hist [NCYC+8];

  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: one output pixel from the configs in force at mask, scanline and border time.
  function automatic logic [NCH*OB-1:0] model_pix(rec_t r, cfg_t cm, cfg_t cs, cfg_t cb, int fadev);
    logic [NCH*OB-1:0] o;
    int  lo, hi, vlo, vhi, d, f;
    bit  masked, dark;
    lo  = cm.hs + cm.hm;
    hi  = cm.hs + cm.ha - cm.hm;
    vlo = cm.vs + cm.vm;
    vhi = cm.vs + cm.va - cm.vm;
    masked = (r.h < lo) || (r.h >= hi) || (r.v < vlo) || (r.v >= vhi);
    case (cs.mode)
      1:       dark = ((cs.slm >> r.line) & 1) == 1;
      2:       dark = (r.col == 0);
      3:       dark = (((cs.slm >> r.line) & 1) ^ cs.par) == 1;
      default: dark = 1'b0;
    endcase
    o = '0;
    for (int c = 0; c < NCH; c++) begin
      d = (r.pix >> (4 * c)) & 15;
      f = d * (fadev + 2);
      if (f > 255) f = 255;
      if (dark) f = (f > cs.str) ? f - cs.str : 0;
      if (masked) f = cb.br * 16;
      o[c*OB +: OB] = 8'(f);
    end
    return o;
  endfunction

  function automatic cfg_t plan(int idx);
    cfg_t c;
    c = '{default: 0};
    c.ha = 4095; c.va = 2047; c.br = 3;
    case (idx)
      1: begin c.mode = 1; c.str = 'h3F; c.slm = 'h02; end
      2, 3: begin c.mode = 3; c.str = 'h40; c.slm = 'h01; end
      4: begin c.mode = 2; c.str = 'h80; end
      5: begin c.hs = 38; c.ha = 960; c.hm = 96; c.vs = 10; c.va = 500; c.vm = 20; end
      6: begin c.mode = 1; c.str = 'h3F; c.slm = 'h02; c.ha = 10; c.hm = 100; c.br = 'hA; end
      default: begin
        c.mode = $urandom_range(0, 3);   c.str = $urandom_range(0, 255);
        c.slm  = $urandom_range(0, 255); c.br  = $urandom_range(0, 15);
        c.hs = $urandom_range(0, 200); c.ha = $urandom_range(0, 1200); c.hm = $urandom_range(0, 150);
        c.vs = $urandom_range(0, 50);  c.va = $urandom_range(0, 700);  c.vm = $urandom_range(0, 60);
      end
    endcase
    return c;
  endfunction

  function automatic rec_t gen_rec(int pos, int frame);
    rec_t r;
    int hb[8] = '{0, 37, 38, 133, 134, 901, 902, 4095};
    int vb[8] = '{0, 9, 10, 29, 30, 489, 490, 2047};
    r.h     = ($urandom_range(0, 1) == 0) ? hb[$urandom_range(0, 7)] : $urandom_range(0, 1200);
    r.v     = ($urandom_range(0, 3) == 0) ? vb[$urandom_range(0, 7)] : $urandom_range(0, 700);
    r.line  = $urandom_range(0, 7);
    r.col   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
    r.hs    = $urandom_range(0, 1);
    r.de    = $urandom_range(0, 1);
    r.vs    = (pos < 3) ? 0 : 1;
    r.frame = frame;
    if ($urandom_range(0, 3) == 0) begin
      r.pix = 'hFFF; r.fade = 15; r.fhi = 1;
    end else begin
      r.pix = $urandom_range(0, 4095); r.fade = $urandom_range(0, 15); r.fhi = $urandom_range(0, 1);
    end
    return r;
  endfunction

  task automatic check_reset_outs();
    check("rst_pix",   64'(pix_out),      64'h0);
    check("rst_pix5",  64'(pix_out2),     64'h0);
    check("rst_hsync", 64'(hsync_out),    64'h1);
    check("rst_vsync", 64'(vsync_out),    64'h1);
    check("rst_de",    64'(de_out),       64'h0);
    check("rst_par",   64'(frame_parity), 64'h0);
  endtask

  // Driver: record k's counters, record k-1's syncs and record k-2's pixel share edge k.
  task automatic drive(input int k);
    hcnt_in      = 12'(rec[k].h);
    vcnt_in      = 11'(rec[k].v);
    line_id_in   = 3'(rec[k].line);
    col_id_in    = 3'(rec[k].col);
    hsync_in     = 1'(rec[k-1].hs);
    vsync_in     = 1'(rec[k-1].vs);
    de_in        = 1'(rec[k-1].de);
    pix_in       = 12'(rec[k-2].pix);
    fade_in      = 4'(rec[k-2].fade);
    fade_hi      = 1'(rec[k-2].fhi);
    cfg_sl_mode  = 2'(drv[k].mode);
    cfg_sl_str   = 8'(drv[k].str);
    cfg_sl_mask  = 8'(drv[k].slm);
    cfg_h_start  = 12'(drv[k].hs);
    cfg_h_active = 12'(drv[k].ha);
    cfg_h_mask   = 12'(drv[k].hm);
    cfg_v_start  = 11'(drv[k].vs);
    cfg_v_active = 11'(drv[k].va);
    cfg_v_mask   = 11'(drv[k].vm);
    cfg_mask_br  = 4'(drv[k].br);
  endtask

  // Monitor: every post-reset output cycle is a pixel; compare against the queue head.
  always @(negedge pclk_act) begin
    logic [EW-1:0] e;
    int            d;
    if (reset_n && cyc > 0) begin
      check("parity",  64'(frame_parity), 64'(hist[cyc].par));
      check("parity5", 64'(par2),         64'(hist[cyc].par));
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("latency", 64'(d), 64'(cyc));
        check("pix_sync", 64'({pix_out2, pix_out, hsync_out, vsync_out, de_out}), 64'(e));
        check("sync5", 64'({hs2, vs2, de2}), 64'(e[2:0]));
      end
    end
  end

  initial begin
    rec_t  idle;
    cfg_t  zero, cur;
    int    pos, frame, vprev_m, last_rst, par, p;
    logic  new_rst;
    logic [NCH*OB-1:0] pe, pe5;
    zero = '{default: 0};
    idle = '{default: 0};
    idle.hs = 1; idle.vs = 1;
    for (int i = 0; i < NCYC + 8; i++) begin
      rec[i] = idle; drv[i] = zero; hist[i] = zero;
    end
    drive(2);
    pos = 0; frame = 0; cur = zero; vprev_m = 1; last_rst = 0;
    for (int k = 2; k < NCYC; k++) begin
      new_rst = (k < 6) || (k >= RST_A && k < RST_A + 3);
      if (new_rst && reset_n) begin
        reset_n = 1'b0;
        #1;
        check_reset_outs();
        exp_q.delete();
        due_q.delete();
      end else if (!new_rst) begin
        reset_n = 1'b1;
      end
      if (k == 4) check_reset_outs();

      rec[k] = gen_rec(pos, frame);
      pos++;
      if (pos == FRAME) begin pos = 0; frame++; end
      drv[k] = drv[k-1];
      if (rec[k-1].vs == 0) drv[k] = plan(rec[k-1].frame);
      else if ($urandom_range(0, 7) == 0) drv[k] = plan(100);
      drive(k);

      @(posedge pclk_act);
      cyc = k;
      if (!reset_n) begin
        cur = zero; vprev_m = 1; last_rst = k;
      end else begin
        if (vprev_m == 1 && rec[k-1].vs == 0) begin
          par = cur.par; cur = drv[k]; cur.par = par ^ 1;
        end
        vprev_m = rec[k-1].vs;
      end
      hist[k] = cur;

      p = k - 4;
      if (p > last_rst && k < NCYC - 1) begin
        pe  = model_pix(rec[p], hist[p], hist[p+3], hist[p+4], rec[p].fade);
        pe5 = model_pix(rec[p], hist[p], hist[p+3], hist[p+4], rec[p].fade + 16 * rec[p].fhi);
        exp_q.push_back({pe5, pe, 1'(rec[p].hs), 1'(rec[p].vs), 1'(rec[p].de)});
        due_q.push_back(k + 1);
      end
      #1;
    end
    #7;
    check("drain", 64'(due_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
